// File: rtl/dcache_sa_wb_if.sv
// Memory-side bus of the set-associative write-back data cache.
//   mem_req   : request, held until mem_rdy
//   mem_we    : 1 = victim write-back, 0 = line fill
//   mem_addr  : line-aligned address
//   mem_wdata : victim line during write-back
//   mem_rdy   : one-cycle accept / fill-data-valid strobe
//   mem_rdata : fill line
// master = cache, slave = memory model.
interface dcache_sa_wb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdy, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdy, mem_rdata
  );
endinterface

// File: rtl/dcache_sa_wb.sv
// N-way set-associative data cache, write-back / write-allocate.
// Combinational lookup for the MEM stage; on a miss a small FSM writes back
// a dirty victim (WB) and then refills the line (FILL), after which the held
// request hits. Replacement: lowest invalid way, else per-set round robin.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid_i/req_wr_i  : access request, 1 = store
//   req_byte_i            : 1 = byte access, 0 = word access
//   req_addr_i/req_wdata_i: byte address, store data (byte stores use [7:0])
//   rdata_o               : load data (byte loads zero-extended), 0 on no hit
//   cache_hit_o, stall_o  : combinational hit / pipeline hold
//   mem                   : memory bus (master side)
module dcache_sa_wb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned NSETS  = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  input  logic                req_wr_i,
  input  logic                req_byte_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic [31:0]         rdata_o,
  output logic                cache_hit_o,
  output logic                stall_o,
  dcache_sa_wb_if.master      mem
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(NSETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WORDS  = LINE_W / 32;
  localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_e;

  // Cache state
  logic [NSETS-1:0][WAYS-1:0]  valid_q;
  logic [NSETS-1:0][WAYS-1:0]  dirty_q;
  logic [NSETS-1:0][WAY_W-1:0] rr_q;
  logic [TAG_W-1:0]            tag_q  [NSETS][WAYS];
  logic [LINE_W-1:0]           data_q [NSETS][WAYS];

  // Miss FSM and registered memory-bus outputs
  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  // Address split
  logic [IDX_W-1:0]  idx_c;
  logic [TAG_W-1:0]  tag_c;
  logic [WSEL_W-1:0] wsel_c;
  logic [1:0]        bsel_c;

  assign idx_c  = req_addr_i[OFF_W +: IDX_W];
  assign tag_c  = req_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel_c = WSEL_W'(req_addr_i[OFF_W-1:0] >> 2);
  assign bsel_c = req_addr_i[1:0];

  // Tag compare across the ways of the addressed set
  logic             hit_any_c;
  logic [WAY_W-1:0] hit_way_c;

  always_comb begin
    hit_any_c = 1'b0;
    hit_way_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx_c][WAY_W'(w)] && (tag_q[idx_c][WAY_W'(w)] == tag_c)) begin
        hit_any_c = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  logic             vict_found_c;
  logic [WAY_W-1:0] vict_c;

  always_comb begin
    vict_found_c = 1'b0;
    vict_c       = rr_q[idx_c];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vict_found_c && !valid_q[idx_c][WAY_W'(w)]) begin
        vict_found_c = 1'b1;
        vict_c       = WAY_W'(w);
      end
    end
  end

  // Lookup results are only meaningful while idle
  logic              in_idle_c;
  logic              store_c;
  logic              fill_c;
  logic [LINE_W-1:0] hit_line_c;
  logic [31:0]       hit_word_c;
  logic [LINE_W-1:0] st_line_c;

  assign in_idle_c   = (state_q == S_IDLE);
  assign cache_hit_o = in_idle_c & req_valid_i & hit_any_c;
  assign stall_o     = !in_idle_c | (req_valid_i & !hit_any_c);
  assign store_c     = cache_hit_o & req_wr_i;
  assign fill_c      = (state_q == S_FILL) & mem.mem_rdy;
  assign hit_line_c  = data_q[idx_c][hit_way_c];
  assign hit_word_c  = hit_line_c[wsel_c*32 +: 32];

  // Load data select, zero when not hitting
  always_comb begin
    rdata_o = '0;
    if (cache_hit_o) begin
      if (req_byte_i) rdata_o = {24'b0, hit_word_c[bsel_c*8 +: 8]};
      else            rdata_o = hit_word_c;
    end
  end

  // Store merge into the hit line
  always_comb begin
    st_line_c = hit_line_c;
    if (req_byte_i) st_line_c[wsel_c*32 + bsel_c*8 +: 8] = req_wdata_i[7:0];
    else            st_line_c[wsel_c*32 +: 32]           = req_wdata_i;
  end

  // Miss FSM: next state and next memory-bus outputs
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && !hit_any_c) begin
          victim_d  = vict_c;
          mem_req_d = 1'b1;
          if (valid_q[idx_c][vict_c] && dirty_q[idx_c][vict_c]) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx_c][vict_c], idx_c, {OFF_W{1'b0}}};
            mem_wdata_d = data_q[idx_c][vict_c];
          end else begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag_c, idx_c, {OFF_W{1'b0}}};
          end
        end
      end
      S_WB: begin
        if (mem.mem_rdy) begin
          state_d     = S_FILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = {tag_c, idx_c, {OFF_W{1'b0}}};
          mem_wdata_d = '0;
        end
      end
      S_FILL: begin
        if (mem.mem_rdy) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // FSM, memory-bus registers and valid/dirty/round-robin state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      victim_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (fill_c) begin
        valid_q[idx_c][victim_q] <= 1'b1;
        dirty_q[idx_c][victim_q] <= 1'b0;
        rr_q[idx_c]              <= (WAYS > 1) ? WAY_W'(victim_q + 1'b1) : '0;
      end
      if (store_c) dirty_q[idx_c][hit_way_c] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_c) begin
      data_q[idx_c][victim_q] <= mem.mem_rdata;
      tag_q[idx_c][victim_q]  <= tag_c;
    end else if (store_c) begin
      data_q[idx_c][hit_way_c] <= st_line_c;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative data cache with write-back and write-allocate. Successor to the direct-mapped, read-fill-only data cache in the monocycle datapath.
- Adds three things the direct-mapped cache lacks: configurable ways/sets/line width, byte/word stores with dirty tracking, and a miss FSM that evicts dirty victims to memory before refilling.
- Sits between the MEM stage and the memory model, using a request/ready handshake on the memory side.

Parameters:
- ADDR_W, 32, virtual address width.
- LINE_W, 128, line width in bits; power of 2, at least 32.
- NSETS, 4, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, at least 1.
- Derived widths: OFF_W = log2(LINE_W/8); IDX_W = log2(NSETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request from the MEM stage.
- req_wr  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_W  byte address; word accesses ignore addr[1:0].
- req_wdata  in  32  store data; byte stores use [7:0].
- rdata  out  32  load data; byte loads are zero-extended.
- cache_hit  out  1  combinational tag match in a valid way.
- stall  out  1  pipeline must hold the request and retry.
- mem_req  out  1  memory request, held until mem_rdy.
- mem_we  out  1  1 = write-back, 0 = line fill.
- mem_addr  out  ADDR_W  line-aligned address (offset bits = 0).
- mem_wdata  out  LINE_W  victim line during write-back.
- mem_rdy  in  1  memory accepts the write / fill data is valid, for one cycle.
- mem_rdata  in  LINE_W  fill line.

Behaviour:
- Address split: offset = addr[OFF_W-1:0], index = addr[OFF_W+IDX_W-1:OFF_W], tag = upper TAG_W bits.
- Per-way state: valid, dirty, tag, data. Per-set state: round-robin pointer rr.
- Lookup is combinational in IDLE.
  - cache_hit = req_valid & any way matches (valid & tag equal).
  - rdata = selected word/byte of the hit way. rdata = 0 when not hitting.
- Store hit: at the clock edge, merge the word (or byte lane addr[1:0]) into the line and set dirty. stall = 0.
- Load hit: stall = 0, no state change.
- req_valid = 0: no state change; cache_hit = 0, stall = 0.
- Miss in IDLE: stall = 1 combinationally. Next state is WB if the victim is valid & dirty, else FILL.
- Victim selection: lowest-index invalid way; if all ways are valid, way rr[index]. The victim is latched at miss detection.
- WB state: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line. Outputs stay stable until mem_rdy; on mem_rdy, go to FILL.
- FILL state: mem_req = 1, mem_we = 0, mem_addr = {req tag, index, 0}. On mem_rdy:
  - write mem_rdata, tag, valid = 1, dirty = 0 into the victim way;
  - rr[index] = (victim + 1) mod WAYS;
  - go to IDLE.
- stall = 1 throughout WB and FILL, and cache_hit = 0 there.
- After the fill, the held request hits on the next cycle. A store is merged then, not during FILL.
- The requester must hold req_* constant while stall = 1. Behaviour is undefined otherwise.
- mem_rdy while mem_req = 0 is ignored.
- WAYS = 1 degenerates to direct-mapped; rr is unused.
- Reset (from any state, including mid-WB/FILL):
  - next cycle state = IDLE; all valid/dirty bits = 0; rr = 0;
  - mem_req = 0, mem_we = 0, stall = 0;
  - dirty data is discarded, with no flush;
  - data arrays need not be cleared.
- Reset outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cache_hit = 0, stall = 0, rdata = 0.

Test Plan:
- Defaults. Reset, then load word 0x50 (set 1). Expect cache_hit = 0, stall = 1, mem_req = 1, mem_we = 0, mem_addr = 0x50. Pulse mem_rdy with mem_rdata = 128'h0011_0101_0011_0101_0011_0101_0011_0101. Next cycle: cache_hit = 1, stall = 0, rdata = 32'h0011_0101.
- Store word 0xDEADBEEF @0x54 (hit), then byte store 0xAA @0x55. Then load word 0x54 gives 0xDEADAAEF and byte load 0x55 gives 0x000000AA, with mem_req = 0 throughout.
- Load 0x150: fills way1 with no write-back. Load 0x250: evicts way0. Expect WB first with mem_we = 1, mem_addr = 0x50, mem_wdata[63:32] = 0xDEADAAEF; then FILL with mem_addr = 0x250. A later load 0x150 still hits.
- Hold mem_rdy = 0 for 5 cycles during FILL. mem_req, mem_addr and stall stay stable every cycle; the line completes only on the mem_rdy cycle.
- Assert reset during WB. Next cycle mem_req = 0 and stall = 0; a load to 0x250 then misses and issues FILL directly, with no WB.
- req_valid = 0 with random addr/wdata for 10 cycles. No mem_req, and a following hit returns unchanged data.
